// File: rtl/irda_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | irda_pkg : shared types and constants for the IrDA SIR transmitter  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package irda_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int SUBTICKS_PER_BIT = 16;
  localparam int PULSE_SUBTICKS   = 3;

  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irda_baud_tick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | irda_baud_tick : BAUD_DIV divider producing 1/16-bit sub-ticks      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module irda_baud_tick #(
  parameter int BAUD_DIV = 27
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  output logic       sub_tick,
  output logic [3:0] sub_idx
);
  localparam int            DIV_W    = $clog2(BAUD_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  assign sub_tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      sub_idx <= '0;
    end else if (clear) begin
      div_cnt <= '0;
      sub_idx <= '0;
    end else if (sub_tick) begin
      div_cnt <= '0;
      sub_idx <= sub_idx + 4'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/irda_sir_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | irda_sir_tx : IrDA SIR transmitter, UART framing with RZI pulses    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module irda_sir_tx
  import irda_pkg::*;
#(
  parameter int BAUD_DIV  = 27,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       enable,
  output logic       busy,
  output logic       irda_TXD
);
  localparam logic       HAS_PARITY = (PARITY != PARITY_NONE);
  localparam logic [2:0] STOP_LAST  = 3'(STOP_BITS - 1);
  localparam logic [3:0] SUB_LAST   = 4'(SUBTICKS_PER_BIT - 1);
  localparam logic [3:0] PULSE_END  = 4'(PULSE_SUBTICKS);

  state_t     state, state_nxt;
  logic       buf_full;
  logic [7:0] buf_data;
  logic [7:0] shreg, shreg_nxt;
  logic       par_bit, par_nxt;
  logic [2:0] bit_cnt, cnt_nxt;
  logic       load, shift, transfer, bit_end, sub_tick, bit_val, txd_nxt;
  logic [3:0] sub_idx, idx_nxt;

  irda_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (load),
    .sub_tick (sub_tick),
    .sub_idx  (sub_idx)
  );

  assign in_ready = !buf_full;
  assign transfer = in_valid && !buf_full;
  assign busy     = (state != ST_IDLE) || buf_full;
  assign bit_end  = sub_tick && (sub_idx == SUB_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    cnt_nxt   = bit_cnt;
    case (state)
      ST_IDLE: begin
        if (buf_full && enable) begin
          state_nxt = ST_START;
          load      = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_nxt = ST_DATA;
          cnt_nxt   = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
            cnt_nxt   = 3'd0;
            state_nxt = HAS_PARITY ? ST_PARITY : ST_STOP;
          end else begin
            cnt_nxt = bit_cnt + 3'd1;
            shift   = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_nxt = ST_STOP;
          cnt_nxt   = 3'd0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            cnt_nxt = 3'd0;
            // Back-to-back frames start with no idle gap.
            if (buf_full && enable) begin
              state_nxt = ST_START;
              load      = 1'b1;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // TXD is computed from the state/bit/sub-tick that will hold after this edge.
  always_comb begin
    shreg_nxt = load ? buf_data : (shift ? {1'b0, shreg[7:1]} : shreg);
    par_nxt   = load ? parity_bit(buf_data, PARITY) : par_bit;
    idx_nxt   = load ? 4'd0 : (sub_tick ? sub_idx + 4'd1 : sub_idx);
    case (state_nxt)
      ST_START:  bit_val = 1'b0;
      ST_DATA:   bit_val = shreg_nxt[0];
      ST_PARITY: bit_val = par_nxt;
      default:   bit_val = 1'b1;
    endcase
    txd_nxt = !bit_val && (idx_nxt < PULSE_END);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_full <= 1'b0;
      buf_data <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      bit_cnt  <= '0;
      irda_TXD <= 1'b0;
    end else begin
      if (transfer) begin
        buf_full <= 1'b1;
        buf_data <= in_data;
      end else if (load) begin
        buf_full <= 1'b0;
      end
      shreg    <= shreg_nxt;
      par_bit  <= par_nxt;
      bit_cnt  <= cnt_nxt;
      irda_TXD <= txd_nxt;
    end
  end

endmodule
`default_nettype wire
